// File: rtl/vector_mem_seq.sv
// vector_mem_seq: splits a scalar or 128-bit vector MEM access into 32-bit data-memory beats
module vector_mem_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_mem_read,
  input  logic         mem_mem_write,
  input  logic         mem_vector_op,
  input  logic [31:0]  mem_addr,
  input  logic [127:0] mem_write_data,
  output logic         dm_req,
  output logic         dm_we,
  output logic [31:0]  dm_addr,
  output logic [31:0]  dm_wdata,
  input  logic         dm_ack,
  input  logic [31:0]  dm_rdata,
  output logic         seq_stall,
  output logic [127:0] seq_rdata,
  output logic         seq_done
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t       state;
  logic [31:0]  addr_q;
  logic [127:0] data_q;
  logic         vec_q;
  logic [1:0]   beat;
  logic         start;
  logic         last;
  assign start     = mem_mem_read | mem_mem_write;
  assign last      = beat == (vec_q ? 2'd3 : 2'd0);
  assign seq_stall = (state == IDLE && start) || state == ACCESS;
  assign dm_addr   = addr_q + {28'd0, beat, 2'b00};
  assign dm_wdata  = data_q[{beat, 5'd0} +: 32];
  // sequencer: latch the op, issue one beat per ack, pulse done, return to idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      vec_q     <= 1'b0;
      beat      <= '0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      seq_rdata <= '0;
      seq_done  <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (state == IDLE && start) begin
        addr_q <= mem_addr;
        data_q <= mem_write_data;
        dm_we  <= mem_mem_write;
        vec_q  <= mem_vector_op;
        beat   <= '0;
        dm_req <= 1'b1;
        state  <= ACCESS;
      end else if (state == ACCESS && dm_ack) begin
        if (!dm_we && vec_q) seq_rdata[{beat, 5'd0} +: 32] <= dm_rdata;
        else if (!dm_we) seq_rdata <= {4{dm_rdata}};
        beat <= beat + 2'd1;
        if (last) begin
          dm_req   <= 1'b0;
          seq_done <= 1'b1;
          state    <= DONE;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_vector_mem_seq.sv
// tb_vector_mem_seq: directed table and corner-case sequences for vector_mem_seq
module tb_vector_mem_seq;
  typedef struct {
    logic         rd, wr, vec;
    logic [31:0]  addr;
    logic [127:0] wd;
    logic         ack;
    logic [31:0]  rdata;
    logic         req, we;
    logic [31:0]  daddr, dwd;
    logic         stall, done;
    logic [127:0] srd;
  } vec_t;
  logic         clk = 1'b0;
  logic         reset;
  logic         rd, wr, vec, ack;
  logic [31:0]  addr, rdata;
  logic [127:0] wd;
  logic         dm_req, dm_we, seq_stall, seq_done;
  logic [31:0]  dm_addr, dm_wdata;
  logic [127:0] seq_rdata;
  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;
  vec_t tbl [15];
  always #5 clk = ~clk;
  vector_mem_seq dut (
    .clk(clk), .reset(reset),
    .mem_mem_read(rd), .mem_mem_write(wr), .mem_vector_op(vec),
    .mem_addr(addr), .mem_write_data(wd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(ack), .dm_rdata(rdata),
    .seq_stall(seq_stall), .seq_rdata(seq_rdata), .seq_done(seq_done)
  );
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  function automatic vec_t mk(input logic r, w, v, input logic [31:0] a, input logic [127:0] d,
                              input logic k, input logic [31:0] rv, input logic q, we_e,
                              input logic [31:0] da, dw, input logic st, dn, input logic [127:0] sr);
    mk = '{r, w, v, a, d, k, rv, q, we_e, da, dw, st, dn, sr};
  endfunction
  task automatic cyc(input string n, input vec_t t);
    rd = t.rd; wr = t.wr; vec = t.vec; addr = t.addr; wd = t.wd; ack = t.ack; rdata = t.rdata;
    @(negedge clk);
    chk({n, " req"}, 128'(dm_req), 128'(t.req));
    chk({n, " stall"}, 128'(seq_stall), 128'(t.stall));
    chk({n, " done"}, 128'(seq_done), 128'(t.done));
    chk({n, " rdata"}, seq_rdata, t.srd);
    if (t.req) begin
      chk({n, " we"}, 128'(dm_we), 128'(t.we));
      chk({n, " addr"}, 128'(dm_addr), 128'(t.daddr));
      chk({n, " wdata"}, 128'(dm_wdata), 128'(t.dwd));
    end
    if (seq_stall) stall_cnt++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [127:0] d, m, wv, ws;
    logic [31:0] lv [4];
    d  = {4{32'hDEADBEEF}};
    wv = {32'h44, 32'h33, 32'h22, 32'h11};
    ws = {96'd0, 32'hCAFE};
    tbl[0]  = mk('1, '0, '0, 32'h100, '0, '0, '0,            '0, '0, '0, '0, '1, '0, '0);
    tbl[1]  = mk('1, '0, '0, 32'h100, '0, '1, 32'hDEADBEEF,  '1, '0, 32'h100, '0, '1, '0, '0);
    tbl[2]  = mk('1, '0, '0, 32'h100, '0, '0, '0,            '0, '0, '0, '0, '0, '1, d);
    tbl[3]  = mk('0, '0, '0, '0, '0, '0, '0,                 '0, '0, '0, '0, '0, '0, d);
    tbl[4]  = mk('0, '1, '1, 32'h200, wv, '1, '0,            '0, '0, '0, '0, '1, '0, d);
    tbl[5]  = mk('0, '1, '1, 32'h200, wv, '1, '0,            '1, '1, 32'h200, 32'h11, '1, '0, d);
    tbl[6]  = mk('0, '1, '1, 32'h200, wv, '1, '0,            '1, '1, 32'h204, 32'h22, '1, '0, d);
    tbl[7]  = mk('0, '1, '1, 32'h200, wv, '1, '0,            '1, '1, 32'h208, 32'h33, '1, '0, d);
    tbl[8]  = mk('0, '1, '1, 32'h200, wv, '1, '0,            '1, '1, 32'h20C, 32'h44, '1, '0, d);
    tbl[9]  = mk('0, '1, '1, 32'h200, wv, '1, '0,            '0, '0, '0, '0, '0, '1, d);
    tbl[10] = mk('0, '0, '0, '0, '0, '0, '0,                 '0, '0, '0, '0, '0, '0, d);
    tbl[11] = mk('1, '1, '0, 32'h40, ws, '0, '0,             '0, '0, '0, '0, '1, '0, d);
    tbl[12] = mk('1, '1, '0, 32'h40, ws, '1, 32'h12345678,   '1, '1, 32'h40, 32'hCAFE, '1, '0, d);
    tbl[13] = mk('1, '1, '0, 32'h40, ws, '0, '0,             '0, '0, '0, '0, '0, '1, d);
    tbl[14] = mk('0, '0, '0, '0, '0, '0, '0,                 '0, '0, '0, '0, '0, '0, d);
    reset = 1'b0; rd = 0; wr = 0; vec = 0; addr = '0; wd = '0; ack = 0; rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req", 128'(dm_req), 128'(0));
    chk("reset we", 128'(dm_we), 128'(0));
    chk("reset addr", 128'(dm_addr), 128'(0));
    chk("reset wdata", 128'(dm_wdata), 128'(0));
    chk("reset rdata", seq_rdata, '0);
    chk("reset done", 128'(seq_done), 128'(0));
    chk("reset stall", 128'(seq_stall), 128'(0));
    reset = 1'b1;
    for (int i = 0; i < 15; i++) cyc($sformatf("row%0d", i), tbl[i]);
    lv = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    m = d;
    stall_cnt = 0;
    cyc("vld start", mk('1, '0, '1, 32'h300, '0, '0, '0, '0, '0, '0, '0, '1, '0, m));
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 2; w++)
        cyc($sformatf("vld wait b%0d w%0d", b, w),
            mk('1, '0, '1, 32'h300, '0, '0, '0, '1, '0, 32'h300 + 32'(4 * b), '0, '1, '0, m));
      cyc($sformatf("vld ack b%0d", b),
          mk('1, '0, '1, 32'h300, '0, '1, lv[b], '1, '0, 32'h300 + 32'(4 * b), '0, '1, '0, m));
      m[32 * b +: 32] = lv[b];
    end
    cyc("vld done", mk('1, '0, '0, 32'h500, '0, '0, '0, '0, '0, '0, '0, '0, '1, m));
    chk("vld stall cycles", 128'(stall_cnt), 128'(13));
    cyc("b2b start", mk('1, '0, '0, 32'h500, '0, '0, '0, '0, '0, '0, '0, '1, '0, m));
    cyc("b2b beat", mk('1, '0, '0, 32'h500, '0, '1, 32'h55, '1, '0, 32'h500, '0, '1, '0, m));
    m = {4{32'h55}};
    cyc("b2b done", mk('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '1, m));
    cyc("rst vld start", mk('1, '0, '1, 32'h600, '0, '0, '0, '0, '0, '0, '0, '1, '0, m));
    cyc("rst vld b0", mk('1, '0, '1, 32'h600, '0, '1, 32'hB0, '1, '0, 32'h600, '0, '1, '0, m));
    m[31:0] = 32'hB0;
    cyc("rst vld b1", mk('1, '0, '1, 32'h600, '0, '1, 32'hB1, '1, '0, 32'h604, '0, '1, '0, m));
    ack = 1'b0;
    #2;
    chk("rst pre addr", 128'(dm_addr), 128'(32'h608));
    reset = 1'b0;
    #1;
    chk("rst async req", 128'(dm_req), 128'(0));
    chk("rst async rdata", seq_rdata, '0);
    chk("rst async stall with op", 128'(seq_stall), 128'(1));
    rd = 1'b0; vec = 1'b0;
    #1;
    chk("rst async stall idle", 128'(seq_stall), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("post rst idle", mk('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0));
    cyc("post rst idle2", mk('0, '0, '0, '0, '0, '1, '0, '0, '0, '0, '0, '0, '0, '0));
    cyc("restart start", mk('1, '0, '0, 32'h700, '0, '0, '0, '0, '0, '0, '0, '1, '0, '0));
    cyc("restart beat", mk('1, '0, '0, 32'h700, '0, '1, 32'h77, '1, '0, 32'h700, '0, '1, '0, '0));
    cyc("restart done", mk('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '1, {4{32'h77}}));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
